rf_multiport: RTL and testbench



---
 rtl/rf_multiport.sv | 145 ++++++++++++++
 tb/tb_rf_multiport.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-port register file with a busy scoreboard.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ra / rd           NRD read ports (address / data), packed per port
//   rd_busy           scoreboard bit of each read address, always combinational
//   wa / wd / we      NWR write ports (address / data / enable), packed per port
//   alloc_valid/addr  marks one register as pending (producer issued)
//   busy_vec          full scoreboard state
//   wr_collision      pulses for one cycle after two enabled write ports hit
//                     the same (non-dropped) address
module rf_multiport #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2**AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*XLEN-1:0]   wd,
    input  logic [NWR-1:0]        we,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    output logic [DEPTH-1:0]      busy_vec,
    output logic                  wr_collision
);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [NWR-1:0]   we_eff;
    logic             coll_d;
    logic [DEPTH-1:0] busy_next;
    logic [XLEN-1:0]  stored [NRD];
    logic [XLEN-1:0]  fwd    [NRD];
    logic [XLEN-1:0]  sel    [NRD];
    logic             alloc_eff;

    // Writes to register 0 are dropped entirely when it is hardwired to zero,
    // so they neither commit, forward, clear busy, nor count as collisions.
    always_comb begin
        we_eff = '0;
        for (int j = 0; j < NWR; j++) begin
            we_eff[j] = we[j] && !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0));
        end
    end

    assign alloc_eff = alloc_valid && !((ZERO_REG != 0) && (alloc_addr == '0));

    always_comb begin
        coll_d = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (we_eff[j] && we_eff[k] && (wa[j*AW +: AW] == wa[k*AW +: AW])) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    // Ascending port order: the highest-indexed port's assignment lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we_eff[j]) begin
                    regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Alloc is applied after the write clears so a new producer wins over
    // the completing one on the same register.
    always_comb begin
        busy_next = busy_vec;
        for (int j = 0; j < NWR; j++) begin
            if (we_eff[j]) begin
                busy_next[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_eff) begin
            busy_next[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec     <= '0;
            wr_collision <= 1'b0;
        end else begin
            busy_vec     <= busy_next;
            wr_collision <= coll_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            stored[i] = regs[ra[i*AW +: AW]];
            fwd[i]    = stored[i];
            for (int j = 0; j < NWR; j++) begin
                if (we_eff[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                    fwd[i] = wd[j*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (ra[i*AW +: AW] == '0)) begin
                stored[i] = '0;
                fwd[i]    = '0;
            end
            sel[i]     = (BYPASS != 0) ? fwd[i] : stored[i];
            rd_busy[i] = busy_vec[ra[i*AW +: AW]];
        end
    end

    if (READ_REG != 0) begin : g_rreg
        logic [NRD*XLEN-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                for (int i = 0; i < NRD; i++) begin
                    rd_q[i*XLEN +: XLEN] <= sel[i];
                end
            end
        end
        assign rd = rd_q;
    end else begin : g_comb
        always_comb begin
            rd = '0;
            for (int i = 0; i < NRD; i++) begin
                rd[i*XLEN +: XLEN] = sel[i];
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Two register files share the write/alloc side: one with combinational
// bypassed reads (2 ports), one with registered non-bypassed reads (4 ports).
// A single array model tracks contents, busy bits and the collision flag.
module tb_rf_multiport;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NWR   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2*AW-1:0]    ra0;
    logic [2*XLEN-1:0]  rd0;
    logic [1:0]         rd_busy0;
    logic [DEPTH-1:0]   busy_vec0;
    logic               coll0;
    logic [4*AW-1:0]    ra1;
    logic [4*XLEN-1:0]  rd1;
    logic [3:0]         rd_busy1;
    logic [DEPTH-1:0]   busy_vec1;
    logic               coll1;
    logic [NWR*AW-1:0]  wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]     we;
    logic               alloc_valid;
    logic [AW-1:0]      alloc_addr;

    rf_multiport #(.XLEN(XLEN), .AW(AW), .NRD(2), .NWR(NWR), .READ_REG(0),
                   .BYPASS(1), .ZERO_REG(1)) dut_comb (
        .clk(clk), .reset(reset), .ra(ra0), .rd(rd0), .rd_busy(rd_busy0),
        .wa(wa), .wd(wd), .we(we), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec0), .wr_collision(coll0));

    rf_multiport #(.XLEN(XLEN), .AW(AW), .NRD(4), .NWR(NWR), .READ_REG(1),
                   .BYPASS(0), .ZERO_REG(1)) dut_reg (
        .clk(clk), .reset(reset), .ra(ra1), .rd(rd1), .rd_busy(rd_busy1),
        .wa(wa), .wd(wd), .we(we), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec1), .wr_collision(coll1));

    logic [31:0] mem_m  [DEPTH];
    logic        busy_m [DEPTH];
    logic        coll_m;
    logic [31:0] exp_rd1 [4];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = mem_m[a];
        if (byp) begin
            for (int j = 0; j < NWR; j++)
                if (we[j] && wa[j*AW +: AW] == a) v = wd[j*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic [31:0] busy_pack();
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) r[i] = busy_m[i];
        return r;
    endfunction

    // Advance the model by one edge using the inputs now applied, then clock.
    task automatic tick();
        logic [4:0] a;
        for (int i = 0; i < 4; i++)
            exp_rd1[i] = reset ? 32'd0 : ref_read(ra1[i*AW +: AW], 1'b0);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i]  = 32'd0;
                busy_m[i] = 1'b0;
            end
            coll_m = 1'b0;
        end else begin
            coll_m = we[0] && we[1] && (wa[4:0] == wa[9:5]) && (wa[4:0] != 5'd0);
            for (int j = 0; j < NWR; j++) begin
                a = wa[j*AW +: AW];
                if (we[j] && a != 5'd0) begin
                    mem_m[a]  = wd[j*XLEN +: XLEN];
                    busy_m[a] = 1'b0;
                end
            end
            if (alloc_valid && alloc_addr != 5'd0) busy_m[alloc_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we = '0; wa = '0; wd = '0;
        alloc_valid = 1'b0; alloc_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 2'b11; wa = {5'd3, 5'd4}; wd = {32'h5, 32'h6};
        alloc_valid = 1'b1; alloc_addr = 5'd3; ra0 = '0; ra1 = '0;
        tick();
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            ra0 = {2{a[4:0]}};
            ra1 = {4{a[4:0]}};
            #1;
            n_cmp++;
            if (rd0 !== 64'd0) begin
                n_fail++; $display("FAIL reset_rd0 addr %0d: got %h expected 0", a, rd0);
            end
            n_cmp++;
            if (busy_vec0 !== 32'd0 || busy_vec1 !== 32'd0 || coll0 !== 1'b0 || coll1 !== 1'b0) begin
                n_fail++; $display("FAIL reset_state: busy %h/%h coll %b/%b expected 0", busy_vec0, busy_vec1, coll0, coll1);
            end
            tick();
            n_cmp++;
            if (rd1 !== 128'd0) begin
                n_fail++; $display("FAIL reset_rd1 addr %0d: got %h expected 0", a, rd1);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF};
        ra0 = {5'd0, 5'd5}; ra1 = {15'd0, 5'd5};
        #1;
        n_cmp++;
        if (rd0[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd0[31:0]);
        end
        tick();
        n_cmp++;
        if (rd1[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL nobypass_prewrite: got %h expected 0", rd1[31:0]);
        end
        idle();
        tick();
        n_cmp++;
        if (rd1[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL nobypass_next: got %h expected deadbeef", rd1[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        we = 2'b01; wa = '0; wd = {32'd0, 32'h1234};
        alloc_valid = 1'b1; alloc_addr = 5'd0; ra0 = '0; ra1 = '0;
        #1;
        n_cmp++;
        if (rd0 !== 64'd0) begin
            n_fail++; $display("FAIL zero_bypass: got %h expected 0", rd0);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd0 !== 64'd0 || busy_vec0[0] !== 1'b0 || rd_busy0 !== 2'b00) begin
            n_fail++; $display("FAIL zero_after: rd %h busy0 %b expected 0/0", rd0, busy_vec0[0]);
        end
        tick();
        n_cmp++;
        if (rd1 !== 128'd0) begin
            n_fail++; $display("FAIL zero_rd1: got %h expected 0", rd1);
        end
    endtask

    task automatic test_collision();
        idle();
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        tick();
        idle();
        ra0 = {5'd0, 5'd7};
        #1;
        n_cmp++;
        if (rd0[31:0] !== 32'h22 || rd0[31:0] !== mem_m[7]) begin
            n_fail++; $display("FAIL collision_winner: got %h expected 22", rd0[31:0]);
        end
        n_cmp++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
            n_fail++; $display("FAIL collision_pulse: got %b/%b expected 1", coll0, coll1);
        end
        tick();
        n_cmp++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            n_fail++; $display("FAIL collision_clear: got %b/%b expected 0", coll0, coll1);
        end
        we = 2'b11; wa = '0; wd = {32'h1, 32'h2};
        tick();
        idle();
        n_cmp++;
        if (coll0 !== 1'b0) begin
            n_fail++; $display("FAIL collision_zero_addr: got %b expected 0", coll0);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_valid = 1'b1; alloc_addr = 5'd9; ra0 = {2{5'd9}}; ra1 = {4{5'd9}};
        #1;
        n_cmp++;
        if (rd_busy0 !== 2'b00) begin
            n_fail++; $display("FAIL busy_before_edge: got %b expected 00", rd_busy0);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy0 !== 2'b11 || rd_busy1 !== 4'hF || busy_vec0 !== busy_pack()) begin
            n_fail++; $display("FAIL busy_alloc: got %b/%h vec %h expected 11/f", rd_busy0, rd_busy1, busy_vec0);
        end
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h99};
        #1;
        n_cmp++;
        if (rd_busy0 !== 2'b11) begin
            n_fail++; $display("FAIL busy_no_bypass: got %b expected 11", rd_busy0);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy0 !== 2'b00 || busy_vec0[9] !== 1'b0) begin
            n_fail++; $display("FAIL busy_cleared: got %b expected 00", rd_busy0);
        end
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h77, 32'd0};
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy0 !== 2'b11 || busy_vec1[9] !== 1'b1) begin
            n_fail++; $display("FAIL busy_alloc_wins: got %b expected 11", rd_busy0);
        end
        we = 2'b01; wa = {5'd0, 5'd9};
        tick();
        idle();
    endtask

    task automatic test_read_reg();
        idle();
        we = 2'b11; wa = {5'd4, 5'd3}; wd = {32'd40, 32'd30};
        tick();
        wa = {5'd6, 5'd5}; wd = {32'd60, 32'd50};
        tick();
        idle();
        ra1 = {5'd6, 5'd5, 5'd4, 5'd3};
        tick();
        n_cmp++;
        if (rd1 !== {32'd60, 32'd50, 32'd40, 32'd30}) begin
            n_fail++; $display("FAIL read_reg_latency: got %h expected 3c/32/28/1e", rd1);
        end
        ra1 = {5'd3, 5'd4, 5'd5, 5'd6};
        #1;
        n_cmp++;
        if (rd1 !== {32'd60, 32'd50, 32'd40, 32'd30}) begin
            n_fail++; $display("FAIL read_reg_hold: got %h expected unchanged", rd1);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h99};
        reset = 1'b1; ra1 = {4{5'd3}}; ra0 = {2{5'd3}};
        tick();
        n_cmp++;
        if (rd1 !== 128'd0) begin
            n_fail++; $display("FAIL reset_mid_rd1: got %h expected 0", rd1);
        end
        idle();
        #1;
        n_cmp++;
        if (rd0 !== 64'd0 || busy_vec0 !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_lost: got %h expected 0", rd0);
        end
        tick();
        n_cmp++;
        if (rd1[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_after: got %h expected 0", rd1[31:0]);
        end
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 59) == 0);
            we          = 2'($urandom);
            wa          = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wd          = {$urandom, $urandom};
            alloc_valid = 1'($urandom);
            alloc_addr  = 5'($urandom_range(0, 15));
            ra0         = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            ra1         = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            #1;
            for (int i = 0; i < 2; i++) begin
                a = ra0[i*AW +: AW];
                n_cmp++;
                if (rd0[i*XLEN +: XLEN] !== ref_read(a, 1'b1) || rd_busy0[i] !== busy_m[a]) begin
                    n_fail++; $display("FAIL rand_rd0 cyc %0d port %0d: got %h/%b expected %h/%b",
                        c, i, rd0[i*XLEN +: XLEN], rd_busy0[i], ref_read(a, 1'b1), busy_m[a]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                a = ra1[i*AW +: AW];
                n_cmp++;
                if (rd1[i*XLEN +: XLEN] !== exp_rd1[i] || rd_busy1[i] !== busy_m[a]) begin
                    n_fail++; $display("FAIL rand_rd1 cyc %0d port %0d: got %h/%b expected %h/%b",
                        c, i, rd1[i*XLEN +: XLEN], rd_busy1[i], exp_rd1[i], busy_m[a]);
                end
            end
            n_cmp++;
            if (busy_vec0 !== busy_pack() || busy_vec1 !== busy_pack() || coll0 !== coll_m || coll1 !== coll_m) begin
                n_fail++; $display("FAIL rand_state cyc %0d: busy %h/%h coll %b/%b expected %h/%b",
                    c, busy_vec0, busy_vec1, coll0, coll1, busy_pack(), coll_m);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle();
        ra0 = '0; ra1 = '0;
        for (int i = 0; i < 4; i++) exp_rd1[i] = 32'd0;
        #1;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_read_reg();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
